// File: rtl/acc_pkg.sv
// Shared constants, types and FSM encoding for the requantising row serializer.
package acc_pkg;

  localparam int COLS   = 5;   // lanes per output row
  localparam int ROWS   = 5;   // rows per frame
  localparam int AB_BW  = 25;  // signed width of a biased accumulation
  localparam int OUT_BW = 8;   // unsigned width of a quantised output
  localparam int SH_BW  = 5;   // width of the shift amount
  localparam int ROW_W  = 3;   // width of the row index port

  typedef logic signed [AB_BW-1:0] acc_bias_t;
  typedef logic        [OUT_BW-1:0] q_out_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/relu_requant.sv
// One lane of requantisation: ReLU, rounding right shift, unsigned saturation.
module relu_requant
  import acc_pkg::*;
(
  input  acc_bias_t        x_i,
  input  logic [SH_BW-1:0] s_i,
  output q_out_t           q_o,
  output logic             sat_o
);

  // One spare bit so the rounding increment can never overflow.
  typedef logic [AB_BW:0] wide_t;

  localparam wide_t QMAX = wide_t'((1 << OUT_BW) - 1);

  // Round-half-up right shift of a non-negative value; shifts past the
  // accumulator width collapse to zero.
  function automatic wide_t round_shift(input acc_bias_t x, input logic [SH_BW-1:0] s);
    wide_t xe;
    wide_t half;
    xe = {1'b0, x};
    if (s == '0) begin
      return xe;
    end
    if (int'(s) >= AB_BW) begin
      return '0;
    end
    half = wide_t'(1) << (s - SH_BW'(1));
    return (xe + half) >> s;
  endfunction

  // Clamp to the unsigned output range.
  function automatic q_out_t saturate(input wide_t r);
    if (r > QMAX) begin
      return '1;
    end
    return r[OUT_BW-1:0];
  endfunction

  wide_t r;

  // Negative lanes are zeroed before rounding, so they can never saturate.
  always_comb begin
    r     = x_i[AB_BW-1] ? '0 : round_shift(x_i, s_i);
    q_o   = saturate(r);
    sat_o = (r > QMAX);
  end

endmodule

// File: rtl/requant_serializer.sv
// Captures a ROWS x COLS frame of biased accumulations and streams it out one
// requantised row per valid/ready beat.
module requant_serializer
  import acc_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [ROWS*COLS*AB_BW-1:0]   i_acc_bias,
  input  logic [SH_BW-1:0]             i_shift,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [COLS*OUT_BW-1:0]       o_data,
  output logic [ROW_W-1:0]             o_row,
  output logic                         o_last,
  output logic                         o_sat
);

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [SH_BW-1:0] shift_q;
  acc_bias_t        buf_q [ROWS][COLS];

  logic   last_row;
  logic   beat;
  logic   load;
  q_out_t q_lane   [COLS];
  logic   sat_lane [COLS];

  assign last_row = (row_q == ROW_W'(ROWS - 1));
  assign beat     = o_valid && i_ready;

  // State and row counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // Next-state: advance a row per beat; after the last row either reload
  // (back-to-back frame) or fall back to IDLE.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          load    = 1'b1;
          row_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (beat) begin
          if (!last_row) begin
            row_d = row_q + ROW_W'(1);
          end else if (i_valid) begin
            load    = 1'b1;
            row_d   = '0;
            state_d = SEND;
          end else begin
            row_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        row_d   = '0;
      end
    endcase
  end

  // Handshake outputs; o_ready looks through i_ready so the next frame can
  // load on the same edge the last row leaves.
  always_comb begin
    o_valid = (state_q == SEND);
    o_last  = (state_q == SEND) && last_row;
    o_ready = (state_q == IDLE) || ((state_q == SEND) && last_row && i_ready);
  end

  // Frame buffer and shift amount, written only on frame accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          buf_q[r][c] <= '0;
        end
      end
    end else if (load) begin
      shift_q <= i_shift;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          buf_q[r][c] <= acc_bias_t'(i_acc_bias[(r*COLS + c)*AB_BW +: AB_BW]);
        end
      end
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_lane
    relu_requant u_lane (
      .x_i   (buf_q[row_q][c]),
      .s_i   (shift_q),
      .q_o   (q_lane[c]),
      .sat_o (sat_lane[c])
    );
    assign o_data[c*OUT_BW +: OUT_BW] = q_lane[c];
  end

  // Row-level saturation flag is the OR of the lane flags.
  always_comb begin
    o_sat = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      o_sat = o_sat | sat_lane[c];
    end
  end

  assign o_row = row_q;

endmodule

// File: tb/tb_requant_serializer.sv
// Scoreboard bench for requant_serializer: directed frames push expected rows,
// a negedge monitor pops and compares on every output handshake.
module tb_requant_serializer;
  import acc_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       i_valid;
  logic                       o_ready;
  logic [ROWS*COLS*AB_BW-1:0] i_acc_bias;
  logic [SH_BW-1:0]           i_shift;
  logic                       o_valid;
  logic                       i_ready;
  logic [COLS*OUT_BW-1:0]     o_data;
  logic [ROW_W-1:0]           o_row;
  logic                       o_last;
  logic                       o_sat;

  requant_serializer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_acc_bias (i_acc_bias),
    .i_shift    (i_shift),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_row      (o_row),
    .o_last     (o_last),
    .o_sat      (o_sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [COLS*OUT_BW-1:0] data;
    logic [ROW_W-1:0]       row;
    logic                   last;
    logic                   sat;
  } beat_t;

  beat_t exp_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  logic [ROWS*COLS*AB_BW-1:0] frm;

  task automatic chk(input string nm, input longint act, input longint req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  function automatic logic [COLS*OUT_BW-1:0] pack5(input int a, input int b, input int c,
                                                   input int d, input int e);
    return {OUT_BW'(e), OUT_BW'(d), OUT_BW'(c), OUT_BW'(b), OUT_BW'(a)};
  endfunction

  task automatic push_row(input int r, input int a, input int b, input int c,
                          input int d, input int e, input logic s);
    beat_t bt;
    bt.data = pack5(a, b, c, d, e);
    bt.row  = ROW_W'(r);
    bt.last = (r == ROWS - 1);
    bt.sat  = s;
    exp_q.push_back(bt);
  endtask

  task automatic push_const_rows(input int from, input int v);
    for (int r = from; r < ROWS; r++) push_row(r, v, v, v, v, v, 1'b0);
  endtask

  task automatic set_lane(input int k, input int v);
    frm[k*AB_BW +: AB_BW] = AB_BW'(v);
  endtask

  // Offer frm with shift sh; returns #1 after the accepting edge.
  task automatic send_frame(input logic [SH_BW-1:0] sh);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    i_acc_bias = frm;
    i_shift    = sh;
    i_valid    = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    i_valid    = 1'b0;
    i_acc_bias = ~frm;
    i_shift    = 5'd1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!o_valid && exp_q.size() == 0) break;
    end
    chk("drain_left", longint'(exp_q.size()), 0);
  endtask

  // Monitor: every accepted beat is compared against the oldest expectation.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", longint'(o_data), longint'(e.data));
        chk("beat_row",  longint'(o_row),  longint'(e.row));
        chk("beat_last", longint'(o_last), longint'(e.last));
        chk("beat_sat",  longint'(o_sat),  longint'(e.sat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    i_valid    = 1'b0;
    i_ready    = 1'b0;
    i_shift    = '0;
    frm        = '0;
    i_acc_bias = '0;

    // Reset and idle state
    repeat (3) @(posedge clk);
    #1;
    chk("valid_in_reset", longint'(o_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", longint'(o_ready), 1);
    chk("idle_valid", longint'(o_valid), 0);
    chk("idle_data",  longint'(o_data),  0);
    chk("idle_row",   longint'(o_row),   0);
    chk("idle_last",  longint'(o_last),  0);
    chk("idle_sat",   longint'(o_sat),   0);
    i_ready = 1'b1;

    // Rounding and saturation, shift 2
    frm = '0;
    set_lane(0, 1000); set_lane(1, 6); set_lane(2, 1023); set_lane(3, -5); set_lane(4, 0);
    push_row(0, 250, 2, 255, 0, 0, 1'b1);
    push_const_rows(1, 0);
    send_frame(5'd2);
    drain();

    // Shift 0: pass-through with clamp
    frm = '0;
    set_lane(0, 200); set_lane(1, 300); set_lane(2, 255); set_lane(3, -1); set_lane(4, 1);
    push_row(0, 200, 255, 255, 0, 1, 1'b1);
    push_const_rows(1, 0);
    send_frame(5'd0);
    drain();

    // Full frame, lane k = 4k, shift 2: row r carries 5r..5r+4
    for (int k = 0; k < ROWS*COLS; k++) set_lane(k, 4*k);
    for (int r = 0; r < ROWS; r++) push_row(r, 5*r, 5*r+1, 5*r+2, 5*r+3, 5*r+4, 1'b0);
    send_frame(5'd2);
    chk("first_row_latency_valid", longint'(o_valid), 1);
    chk("first_row_latency_row",   longint'(o_row),   0);
    repeat (5) @(posedge clk);
    #1;
    chk("valid_after_frame", longint'(o_valid), 0);
    drain();

    // Backpressure at row 1 for 3 cycles
    for (int r = 0; r < ROWS; r++) push_row(r, 5*r, 5*r+1, 5*r+2, 5*r+3, 5*r+4, 1'b0);
    send_frame(5'd2);
    @(posedge clk); #1;
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", longint'(o_valid), 1);
      chk("stall_row",   longint'(o_row),   1);
      chk("stall_data",  longint'(o_data),  longint'(pack5(5, 6, 7, 8, 9)));
      @(posedge clk); #1;
    end
    i_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_valid_after_8", longint'(o_valid), 0);
    drain();

    // Back-to-back: A (1000, shift 2 -> 250) then B (1000, shift 3 -> 125)
    for (int k = 0; k < ROWS*COLS; k++) set_lane(k, 1000);
    push_const_rows(0, 250);
    send_frame(5'd2);
    push_const_rows(0, 125);
    i_acc_bias = frm;
    i_shift    = 5'd3;
    i_valid    = 1'b1;
    for (int i = 0; i < ROWS - 1; i++) begin
      @(negedge clk);
      chk("b2b_not_ready", longint'(o_ready), 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("b2b_ready_on_last", longint'(o_ready), 1);
    chk("b2b_last",          longint'(o_last),  1);
    @(posedge clk); #1;
    i_valid    = 1'b0;
    i_acc_bias = '0;
    chk("b2b_no_bubble_valid", longint'(o_valid), 1);
    chk("b2b_no_bubble_row",   longint'(o_row),   0);
    drain();

    // Large shifts flush everything to zero
    for (int k = 0; k < ROWS*COLS; k++) set_lane(k, 1000*k + 7);
    push_const_rows(0, 0);
    send_frame(5'd24);
    drain();
    push_const_rows(0, 0);
    send_frame(5'd31);
    drain();

    // Asynchronous reset in the middle of a frame
    for (int k = 0; k < ROWS*COLS; k++) set_lane(k, 4*k);
    for (int r = 0; r < ROWS; r++) push_row(r, 5*r, 5*r+1, 5*r+2, 5*r+3, 5*r+4, 1'b0);
    send_frame(5'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_at_row2", longint'(o_row), 2);
    rst_n = 1'b0;
    #1;
    chk("abort_valid_drop", longint'(o_valid), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_row",   longint'(o_row),   0);
    chk("abort_valid", longint'(o_valid), 0);
    chk("abort_idle",  longint'(o_ready), 1);
    repeat (3) @(negedge clk);
    chk("abort_no_resume", longint'(o_valid), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
